// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU constants, FSM encodings, operand class codes and
//               the unpacked-operand record used by multiplier and divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;
    localparam int ACC_W = 2 * SIG_W;

    // Sequencer states
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_unpack = 3'd1;
    localparam logic [2:0] c_st_mul    = 3'd2;
    localparam logic [2:0] c_st_norm   = 3'd3;
    localparam logic [2:0] c_st_round  = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    // Operand classes
    localparam logic [2:0] c_cls_zero = 3'd0;
    localparam logic [2:0] c_cls_sub  = 3'd1;
    localparam logic [2:0] c_cls_norm = 3'd2;
    localparam logic [2:0] c_cls_inf  = 3'd3;
    localparam logic [2:0] c_cls_nan  = 3'd4;

    localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
    localparam logic [30:0] c_inf_mag  = 31'h7F80_0000;
    localparam logic [30:0] c_zero_mag = 31'h0000_0000;

    // exp is two's complement, unbiased; sig always has bit SIG_W-1 set for finite non-zero
    typedef struct packed {
        logic             sign;
        logic [2:0]       cls;
        logic [EXP_W+1:0] exp;
        logic [SIG_W-1:0] sig;
    } fpu_op_t;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_unpack.sv
// ============================================================================
// Module      : fpu_unpack
// Description : Combinational single-precision classifier; subnormals are
//               left-normalised so downstream logic sees a hidden-bit-1 value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [31:0] op,
    output fpu_op_t     res
);

    logic [EXP_W-1:0] w_ef;
    logic [MAN_W-1:0] w_fr;
    logic [4:0]       w_lz;

    assign w_ef = op[30:23];
    assign w_fr = op[22:0];
    assign w_lz = lzc24({1'b0, w_fr});

    always_comb begin
        res.sign = op[31];
        res.cls  = c_cls_norm;
        res.exp  = '0;
        res.sig  = '0;
        if (w_ef == '1) begin
            res.cls = (w_fr == '0) ? c_cls_inf : c_cls_nan;
        end else if (w_ef == '0) begin
            if (w_fr == '0) begin
                res.cls = c_cls_zero;
            end else begin
                // value = 1.f * 2^(1 - BIAS - lzc) once the leading one reaches the hidden position
                res.cls = c_cls_sub;
                res.exp = 10'd1 - 10'(BIAS) - {5'd0, w_lz};
                res.sig = {1'b0, w_fr} << w_lz;
            end
        end else begin
            res.exp = {2'b00, w_ef} - 10'(BIAS);
            res.sig = {1'b1, w_fr};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_mul_seq.sv
// ============================================================================
// Module      : fpu_mul_seq
// Description : Sequential IEEE-754 single-precision multiplier, one shift-add
//               step per cycle, RNE rounding, start/done handshake.
//               Optional exception flags port: define FPU_MUL_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_mul_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] product,
    output logic        busy,
`ifdef FPU_MUL_FLAGS_EN
    output logic        done,
    output logic [3:0]  flags
`else
    output logic        done
`endif
);

    logic [2:0]        r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [4:0]        r_cnt;
    logic [ACC_W-1:0]  r_mcand;
    logic [SIG_W-1:0]  r_mplier;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sign;
    logic signed [11:0] r_exp;
    logic [ACC_W-2:0]  r_sig;
    logic              r_st0;
    logic [31:0]       r_res;

    fpu_op_t w_ua;
    fpu_op_t w_ub;

    fpu_unpack u_unpack_a (.op(r_a), .res(w_ua));
    fpu_unpack u_unpack_b (.op(r_b), .res(w_ub));

    // Special-case detection
    logic        w_sign;
    logic        w_any_nan;
    logic        w_any_inf;
    logic        w_any_zero;
    logic        w_inf_zero;
    logic        w_special;
    logic [31:0] w_spec_res;

    assign w_sign     = w_ua.sign ^ w_ub.sign;
    assign w_any_nan  = (w_ua.cls == c_cls_nan)  || (w_ub.cls == c_cls_nan);
    assign w_any_inf  = (w_ua.cls == c_cls_inf)  || (w_ub.cls == c_cls_inf);
    assign w_any_zero = (w_ua.cls == c_cls_zero) || (w_ub.cls == c_cls_zero);
    assign w_inf_zero = w_any_inf && w_any_zero;
    assign w_special  = w_any_nan || w_any_inf || w_any_zero;

    always_comb begin
        if (w_any_nan || w_inf_zero) begin
            w_spec_res = c_qnan;
        end else if (w_any_inf) begin
            w_spec_res = {w_sign, c_inf_mag};
        end else begin
            w_spec_res = {w_sign, c_zero_mag};
        end
    end

    // Round / denormalise / pack
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_shf;
    logic [ACC_W-1:0]   w_mask;
    logic signed [11:0] w_sh_raw;
    logic signed [11:0] w_exp_fin;
    logic [5:0]         w_sh;
    logic               w_tiny;
    logic               w_g;
    logic               w_st;
    logic               w_up;
    logic               w_ovf;
    logic [SIG_W:0]     w_rnd;
    logic [31:0]        w_rres;

    always_comb begin
        w_ext    = {r_sig, r_st0};
        w_tiny   = (r_exp <= 12'sd0);
        w_sh_raw = 12'sd1 - r_exp;
        w_sh     = 6'd0;
        if (w_tiny) begin
            w_sh = (w_sh_raw > 12'sd48) ? 6'd48 : w_sh_raw[5:0];
        end
        // Bits pushed out by the subnormal shift all fold into sticky
        w_mask    = (48'd1 << w_sh) - 48'd1;
        w_shf     = w_ext >> w_sh;
        w_g       = w_shf[23];
        w_st      = (|w_shf[22:0]) | (|(w_ext & w_mask));
        w_up      = w_g & (w_st | w_shf[24]);
        w_rnd     = {1'b0, w_shf[47:24]} + {24'd0, w_up};
        w_exp_fin = r_exp + {11'd0, w_rnd[24]};
        w_ovf     = !w_tiny && (w_exp_fin >= 12'sd255);
        if (w_tiny) begin
            // A round-up into bit 23 lands on the smallest normal naturally
            w_rres = {r_sign, 7'd0, w_rnd[23:0]};
        end else if (w_ovf) begin
            w_rres = {r_sign, c_inf_mag};
        end else begin
            w_rres = {r_sign, w_exp_fin[7:0], (w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0])};
        end
    end

`ifdef FPU_MUL_FLAGS_EN
    logic       w_inexact;
    logic [3:0] w_rfl;
    logic [3:0] w_sfl;
    logic [3:0] r_fl;

    assign w_inexact = w_g | w_st | w_ovf;
    assign w_rfl     = {1'b0, w_ovf, w_tiny & w_inexact, w_inexact};
    assign w_sfl     = {w_any_nan | w_inf_zero, 3'b000};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_sig    <= '0;
            r_st0    <= 1'b0;
            r_res    <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef FPU_MUL_FLAGS_EN
            r_fl     <= '0;
            flags    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a     <= multiplicand;
                        r_b     <= multiplier;
                        busy    <= 1'b1;
                        r_state <= c_st_unpack;
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                c_st_unpack: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_res   <= w_spec_res;
`ifdef FPU_MUL_FLAGS_EN
                        r_fl    <= w_sfl;
`endif
                        r_state <= c_st_done;
                    end else begin
                        r_exp    <= $signed({{2{w_ua.exp[9]}}, w_ua.exp})
                                  + $signed({{2{w_ub.exp[9]}}, w_ub.exp});
                        r_mcand  <= {24'd0, w_ua.sig};
                        r_mplier <= w_ub.sig;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= c_st_mul;
                    end
                end
                c_st_mul: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= c_st_norm;
                    end
                end
                c_st_norm: begin
                    if (r_acc[47]) begin
                        r_sig <= r_acc[47:1];
                        r_st0 <= r_acc[0];
                        r_exp <= r_exp + 12'(BIAS + 1);
                    end else begin
                        r_sig <= r_acc[46:0];
                        r_st0 <= 1'b0;
                        r_exp <= r_exp + 12'(BIAS);
                    end
                    r_state <= c_st_round;
                end
                c_st_round: begin
                    r_res   <= w_rres;
`ifdef FPU_MUL_FLAGS_EN
                    r_fl    <= w_rfl;
`endif
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    product <= r_res;
`ifdef FPU_MUL_FLAGS_EN
                    flags   <= r_fl;
`endif
                    done    <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_seq.sv
// ============================================================================
// Module      : tb_fpu_mul_seq
// Description : Directed self-checking bench for fpu_mul_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        done;
    logic [3:0]  obs_flags;

    int n_pass  = 0;
    int n_total = 0;

`ifdef FPU_MUL_FLAGS_EN
    logic [3:0] flags;
    assign obs_flags = flags;
`else
    assign obs_flags = 4'b0000;
`endif

    always #5 clk = ~clk;

    fpu_mul_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
`ifdef FPU_MUL_FLAGS_EN
        .done         (done),
        .flags        (flags)
`else
        .done         (done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // poke >= 0 pulses start with other operands that many cycles into the operation
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_p, input int lat,
                          input logic [3:0] exp_f, input logic [3:0] f_mask, input int poke);
        int   n;
        logic busy_ok;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        n       = 0;
        busy_ok = busy;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            start = (n == poke);
            if (n == poke) begin
                multiplicand = 32'h3F80_0000;
                multiplier   = 32'h3F80_0000;
            end
            busy_ok &= busy;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_product"}, product, exp_p);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
`ifdef FPU_MUL_FLAGS_EN
        check({tag, "_flags"}, {28'd0, obs_flags & f_mask}, {28'd0, exp_f & f_mask});
`endif
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin : main
        logic saw_done;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset_product", product, 32'h0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_flags", {28'd0, obs_flags}, 32'd0);
        rst = 1'b0;

        run_op("mul_1p5x2",  32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 28, 4'b0000, 4'hF, -1);
        run_op("rnd_quarter",32'h3EAA_AAAB, 32'h4040_0000, 32'h3F80_0000, 28, 4'b0001, 4'hF, -1);
        run_op("rnd_sticky", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 28, 4'b0001, 4'hF, -1);
        run_op("near_four",  32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 28, 4'b0001, 4'hF, -1);
        run_op("sub_in",     32'h0040_0000, 32'h4000_0000, 32'h0080_0000, 28, 4'b0000, 4'hF, -1);
        run_op("sub_out",    32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 28, 4'b0000, 4'hF, -1);
        run_op("overflow",   32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 28, 4'b0100, 4'hE, -1);
        run_op("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 28, 4'b0011, 4'hF, -1);
        run_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2,  4'b1000, 4'hF, -1);
        run_op("neg_x_inf",  32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000, 2,  4'b0000, 4'hF, -1);
        run_op("nan_in",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 2,  4'b1000, 4'hF, -1);
        run_op("negzero",    32'h8000_0000, 32'h3FC0_0000, 32'h8000_0000, 2,  4'b0000, 4'hF, -1);
        run_op("start_busy", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 28, 4'b0000, 4'hF, 5);

        // Abort in the middle of the shift-add phase (MUL cycle 10 follows edge 12)
        @(negedge clk);
        multiplicand = 32'h3FC0_0000;
        multiplier   = 32'h4000_0000;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_product", product, 32'h0);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        run_op("after_abort", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 28, 4'b0000, 4'hF, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
